// File: rtl/regfilereader_pkg.sv
// Shared decode helpers and widths for the regfile read/write stages.
// Instruction field extraction and PC-as-operand substitution.
package regfilereader_pkg;

  localparam int BIT_WIDTH      = 32;
  localparam int REG_COUNT_L2   = 4;
  localparam int REG_PC_INDEX   = 15;
  localparam int PC_READ_OFFSET = 8;

  typedef logic [BIT_WIDTH-1:0]    word_t;
  typedef logic [REG_COUNT_L2-1:0] reg_t;

  typedef enum logic [1:0] {
    FMT_DP,
    FMT_MUL,
    FMT_SDT,
    FMT_OTHER
  } fmt_e;

  function automatic fmt_e decode_format(word_t inst);
    logic is_mul;
    logic is_dp;
    logic is_sdt;
    fmt_e f;
    // multiply shares the DP opcode space, so carve it out first
    is_mul = (inst[27:22] == 6'b0) && (inst[7:4] == 4'b1001);
    is_dp  = (inst[27:26] == 2'b00) && !is_mul;
    is_sdt = (inst[27:26] == 2'b01);
    f = FMT_OTHER;
    unique case (1'b1)
      is_mul:  f = FMT_MUL;
      is_dp:   f = FMT_DP;
      is_sdt:  f = FMT_SDT;
      default: f = FMT_OTHER;
    endcase
    return f;
  endfunction

  function automatic reg_t decode_Rn(word_t inst);
    return inst[19:16];
  endfunction

  function automatic reg_t decode_Rd(word_t inst);
    return inst[15:12];
  endfunction

  function automatic reg_t decode_Rs(word_t inst);
    return inst[11:8];
  endfunction

  function automatic reg_t decode_Rm(word_t inst);
    return inst[3:0];
  endfunction

  function automatic logic decode_is_store(word_t inst);
    return (decode_format(inst) == FMT_SDT) && !inst[20];
  endfunction

  function automatic logic decode_dp_reg_shift(word_t inst);
    return (decode_format(inst) == FMT_DP) && !inst[25] && inst[4];
  endfunction

  function automatic word_t pc_operand(reg_t addr, word_t value,
                                       word_t pc);
    word_t r;
    if (addr == reg_t'(REG_PC_INDEX))
      r = pc + word_t'(PC_READ_OFFSET);
    else
      r = value;
    return r;
  endfunction

endpackage

// File: rtl/regfilereader_if.sv
// Two combinational regfile read ports.
// master = reader stage, slave = register file.
interface regfilereader_if;
  import regfilereader_pkg::*;

  reg_t  regfile_read_addr1;
  reg_t  regfile_read_addr2;
  word_t regfile_read_value1;
  word_t regfile_read_value2;

  modport master (
    output regfile_read_addr1,
    output regfile_read_addr2,
    input  regfile_read_value1,
    input  regfile_read_value2
  );

  modport slave (
    input  regfile_read_addr1,
    input  regfile_read_addr2,
    output regfile_read_value1,
    output regfile_read_value2
  );
endinterface

// File: rtl/regfilereader.sv
// Operand-fetch stage: reads Rn/Rm, then Rs/Rd when needed,
// and hands registered operands to the executor.
module regfilereader
  import regfilereader_pkg::*;
(
  input  logic  clk,
  input  logic  nreset,
  input  logic  enable,
  output logic  ready,
  input  word_t pc,
  input  word_t decoder_inst,
  regfilereader_if.master rf,
  output word_t reader_inst,
  output word_t Rn_value,
  output word_t Rm_value,
  output word_t Rs_value,
  output word_t Rd_value
);

  typedef enum logic [1:0] {
    IDLE,
    READ_B,
    DONE
  } state_e;

  state_e state;
  state_e state_nxt;
  logic   need_second;
  word_t  op1;
  word_t  op2;

  assign need_second = decode_dp_reg_shift(decoder_inst)
                     || decode_is_store(decoder_inst);

  assign op1 = pc_operand(rf.regfile_read_addr1,
                          rf.regfile_read_value1, pc);
  assign op2 = pc_operand(rf.regfile_read_addr2,
                          rf.regfile_read_value2, pc);

  assign ready = (state == DONE);

  always_comb begin
    state_nxt             = state;
    rf.regfile_read_addr1 = '0;
    rf.regfile_read_addr2 = '0;
    unique case (state)
      IDLE: begin
        rf.regfile_read_addr1 = decode_Rn(decoder_inst);
        rf.regfile_read_addr2 = decode_Rm(decoder_inst);
        if (enable)
          state_nxt = need_second ? READ_B : DONE;
      end
      READ_B: begin
        rf.regfile_read_addr1 = decode_Rs(reader_inst);
        rf.regfile_read_addr2 = decode_Rd(reader_inst);
        state_nxt = enable ? DONE : IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      reader_inst <= '0;
      Rn_value    <= '0;
      Rm_value    <= '0;
      Rs_value    <= '0;
      Rd_value    <= '0;
    end else if (state == IDLE && enable) begin
      reader_inst <= decoder_inst;
      Rn_value    <= op1;
      Rm_value    <= op2;
      Rs_value    <= '0;
      Rd_value    <= '0;
    end else if (state == READ_B && enable) begin
      Rs_value <= decode_dp_reg_shift(reader_inst) ? op1 : '0;
      Rd_value <= decode_is_store(reader_inst) ? op2 : '0;
    end
  end

endmodule

// File: tb/tb_regfilereader.sv
// Scoreboard bench for the operand-fetch stage.
// Directed instructions against a small regfile model.
module tb_regfilereader;
  import regfilereader_pkg::*;

  logic  clk;
  logic  nreset;
  logic  enable;
  logic  ready;
  word_t pc;
  word_t decoder_inst;
  word_t reader_inst;
  word_t Rn_value;
  word_t Rm_value;
  word_t Rs_value;
  word_t Rd_value;

  regfilereader_if rf();

  word_t regs [16];
  int    cyc;
  int    n_checks;
  int    n_fail;

  typedef struct {
    word_t inst;
    word_t rn;
    word_t rm;
    word_t rs;
    word_t rd;
    int    at;
  } exp_t;

  exp_t q[$];

  assign rf.regfile_read_value1 = regs[rf.regfile_read_addr1];
  assign rf.regfile_read_value2 = regs[rf.regfile_read_addr2];

  regfilereader dut (
    .clk          (clk),
    .nreset       (nreset),
    .enable       (enable),
    .ready        (ready),
    .pc           (pc),
    .decoder_inst (decoder_inst),
    .rf           (rf.master),
    .reader_inst  (reader_inst),
    .Rn_value     (Rn_value),
    .Rm_value     (Rm_value),
    .Rs_value     (Rs_value),
    .Rd_value     (Rd_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ready_cycle", cyc, e.at);
        chk("reader_inst", reader_inst, e.inst);
        chk("Rn_value", Rn_value, e.rn);
        chk("Rm_value", Rm_value, e.rm);
        chk("Rs_value", Rs_value, e.rs);
        chk("Rd_value", Rd_value, e.rd);
      end
    end
  end

  // called #1 after a posedge; returns #1 into the DONE cycle
  task automatic issue(word_t inst, bit two,
                       logic [3:0] a1, logic [3:0] a2,
                       logic [3:0] b1, logic [3:0] b2,
                       word_t rn, word_t rm, word_t rs, word_t rd,
                       bit drop);
    exp_t e;
    enable       = 1'b1;
    decoder_inst = inst;
    e = '{inst, rn, rm, rs, rd, cyc + (two ? 2 : 1)};
    q.push_back(e);
    #1;
    chk("addr1_first", 32'(rf.regfile_read_addr1), 32'(a1));
    chk("addr2_first", 32'(rf.regfile_read_addr2), 32'(a2));
    @(posedge clk); #1;
    if (two) begin
      chk("addr1_second", 32'(rf.regfile_read_addr1), 32'(b1));
      chk("addr2_second", 32'(rf.regfile_read_addr2), 32'(b2));
      @(posedge clk); #1;
    end
    if (drop) enable = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam word_t ADD_R2_R0_R1   = 32'hE080_2001;
  localparam word_t ADD_LSL_R6     = 32'hE084_3615;
  localparam word_t STR_R7_R8_R9   = 32'hE788_7009;
  localparam word_t MOV_R0_PC      = 32'hE1A0_000F;
  localparam word_t STR_PC_R0_R1   = 32'hE780_F001;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    enable       = 1'b0;
    decoder_inst = '0;
    pc           = 32'h20;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;
    regs[0]  = 32'd5;
    regs[1]  = 32'd7;
    regs[4]  = 32'd1;
    regs[5]  = 32'd2;
    regs[6]  = 32'd3;
    regs[7]  = 32'hDEAD;
    regs[8]  = 32'h100;
    regs[9]  = 32'd4;
    regs[15] = 32'hBAD0_BAD0;

    nreset = 1'b1;
    idle(2);
    nreset = 1'b0;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_inst", reader_inst, 32'd0);
    chk("rst_Rn", Rn_value, 32'd0);
    chk("rst_Rm", Rm_value, 32'd0);
    chk("rst_Rs", Rs_value, 32'd0);
    chk("rst_Rd", Rd_value, 32'd0);

    issue(ADD_R2_R0_R1, 0, 4'd0, 4'd1, 4'd0, 4'd0,
          32'd5, 32'd7, 32'd0, 32'd0, 1);
    idle(2);
    issue(ADD_LSL_R6, 1, 4'd4, 4'd5, 4'd6, 4'd3,
          32'd1, 32'd2, 32'd3, 32'd0, 1);
    idle(2);
    issue(STR_R7_R8_R9, 1, 4'd8, 4'd9, 4'd0, 4'd7,
          32'h100, 32'd4, 32'd0, 32'hDEAD, 1);
    idle(2);
    issue(MOV_R0_PC, 0, 4'd0, 4'd15, 4'd0, 4'd0,
          32'd5, 32'h28, 32'd0, 32'd0, 1);
    idle(2);
    pc = 32'hFFFF_FFFC;
    issue(MOV_R0_PC, 0, 4'd0, 4'd15, 4'd0, 4'd0,
          32'd5, 32'h4, 32'd0, 32'd0, 1);
    idle(2);
    pc = 32'h20;
    issue(STR_PC_R0_R1, 1, 4'd0, 4'd1, 4'd0, 4'd15,
          32'd5, 32'd7, 32'd0, 32'h28, 1);
    idle(2);

    // reset while the store is in its second read
    enable       = 1'b1;
    decoder_inst = STR_R7_R8_R9;
    idle(1);
    nreset = 1'b1;
    enable = 1'b0;
    idle(1);
    nreset = 1'b0;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_inst", reader_inst, 32'd0);
    chk("abort_Rn", Rn_value, 32'd0);
    chk("abort_Rm", Rm_value, 32'd0);
    chk("abort_Rs", Rs_value, 32'd0);
    chk("abort_Rd", Rd_value, 32'd0);
    idle(4);

    // enable dropped during the second read: no pulse
    enable       = 1'b1;
    decoder_inst = ADD_LSL_R6;
    idle(1);
    chk("drop_addr1", 32'(rf.regfile_read_addr1), 32'd6);
    enable = 1'b0;
    idle(4);

    // back-to-back single reads, pulses two cycles apart
    issue(ADD_R2_R0_R1, 0, 4'd0, 4'd1, 4'd0, 4'd0,
          32'd5, 32'd7, 32'd0, 32'd0, 0);
    idle(1);
    issue(MOV_R0_PC, 0, 4'd0, 4'd15, 4'd0, 4'd0,
          32'd5, 32'h28, 32'd0, 32'd0, 1);
    idle(4);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
